// File: rtl/banked_memory_ctrl.sv
// banked_memory_ctrl: unified instr/data memory with a
// valid/ready request port, read pipeline and data-region clear.
module banked_memory_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int INSTR_WORDS = 16,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              prog_en,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              clr_start,
  output logic              clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] INSTR_C = (ADDR_W+1)'(INSTR_WORDS);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(INSTR_WORDS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH-1);
  localparam logic CLR_OK = (INSTR_WORDS < DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              in_range;
  logic              prot;
  logic              err;
  logic              wr_ok;
  logic [DATA_W-1:0] rd;

  logic [READ_LAT-1:0] pv;
  logic [READ_LAT-1:0] pe;
  logic [DATA_W-1:0]   pd [READ_LAT];

  assign req_ready = rst_n && (state == IDLE);
  assign acc       = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_C;
  assign prot      = req_we && !prog_en &&
                     ({1'b0, req_addr} < INSTR_C);
  assign err       = !in_range || prot;
  assign wr_ok     = acc && req_we && !err;
  assign rd        = (in_range && !req_we) ?
                     mem[req_addr] : '0;

  assign clr_busy  = (state == CLEAR);
  assign rsp_valid = pv[READ_LAT-1];
  assign rsp_err   = pe[READ_LAT-1];
  assign rsp_rdata = pd[READ_LAT-1];

  // Control FSM: sweeps the data region one word per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start && CLR_OK) begin
            state <= CLEAR;
            ptr   <= FIRST;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single write port shared by the sweep and accepted writes
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    else if (wr_ok)     mem[req_addr] <= req_wdata;
  end

  // Response pipeline; read data captured at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < READ_LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= acc;
      pe[0] <= acc && err;
      pd[0] <= acc ? rd : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

endmodule

// File: tb/tb_banked_memory_ctrl.sv
// tb_banked_memory_ctrl: scoreboard bench driving two
// configurations (32 words/lat 1, 24 words/lat 4) in lockstep.
module tb_banked_memory_ctrl;

  localparam int IW = 16;
  localparam int DA = 32;
  localparam int LA = 1;
  localparam int DB = 24;
  localparam int LB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       prog_en = 1'b0;
  logic       clr_start = 1'b0;

  logic       req_ready_a, rsp_valid_a, rsp_err_a, clr_busy_a;
  logic [7:0] rsp_rdata_a;
  logic       req_ready_b, rsp_valid_b, rsp_err_b, clr_busy_b;
  logic [7:0] rsp_rdata_b;

  always #5 clk = ~clk;

  banked_memory_ctrl #(
    .DATA_W(8), .ADDR_W(5), .DEPTH(DA),
    .INSTR_WORDS(IW), .READ_LAT(LA)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .prog_en(prog_en),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a), .clr_start(clr_start),
    .clr_busy(clr_busy_a)
  );

  banked_memory_ctrl #(
    .DATA_W(8), .ADDR_W(5), .DEPTH(DB),
    .INSTR_WORDS(IW), .READ_LAT(LB)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .prog_en(prog_en),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .clr_start(clr_start),
    .clr_busy(clr_busy_b)
  );

  typedef struct packed {
    logic        err;
    logic [7:0]  data;
    logic [31:0] acc;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [7:0]  ma [DA];
  logic [7:0]  mb [DB];
  int          total = 0;
  int          bad = 0;
  logic [31:0] cyc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic req(input logic we, input logic [4:0] a,
                     input logic [7:0] d, input logic pe,
                     input logic clr = 1'b0);
    exp_t e;
    logic er;
    chk("ready_at_issue", {30'd0, req_ready_a, req_ready_b},
        32'd3);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    prog_en   = pe;
    clr_start = clr;
    er = (int'(a) >= DA) || (we && int'(a) < IW && !pe);
    e.err  = er;
    e.data = (!we && !er) ? ma[a] : 8'h00;
    e.acc  = cyc + 1;
    qa.push_back(e);
    if (we && !er) ma[a] = d;
    er = (int'(a) >= DB) || (we && int'(a) < IW && !pe);
    e.err  = er;
    e.data = (!we && !er) ? mb[a] : 8'h00;
    qb.push_back(e);
    if (we && !er) mb[a] = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clr_start = 1'b0;
  endtask

  // Monitor: pops one expectation per response and checks timing
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_rsp", {23'd0, rsp_err_a, rsp_rdata_a},
            {23'd0, e.err, e.data});
        chk("a_latency", cyc, e.acc + LA - 1);
      end
    end
    if (rsp_valid_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_rsp", {23'd0, rsp_err_b, rsp_rdata_b},
            {23'd0, e.err, e.data});
        chk("b_latency", cyc, e.acc + LB - 1);
      end
    end
  end

  initial begin
    int na, nb, viol;
    for (int i = 0; i < DA; i++) ma[i] = '0;
    for (int i = 0; i < DB; i++) mb[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs",
        {26'd0, req_ready_a, req_ready_b, rsp_valid_a,
         rsp_valid_b, clr_busy_a, clr_busy_b}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {30'd0, req_ready_a, req_ready_b},
        32'd3);
    @(posedge clk);
    #1;

    req(1'b1, 5'd20, 8'hA5, 1'b0);
    req(1'b0, 5'd20, 8'h00, 1'b0);

    req(1'b1, 5'd5, 8'h11, 1'b1);
    req(1'b1, 5'd5, 8'h3C, 1'b0);
    req(1'b0, 5'd5, 8'h00, 1'b0);
    req(1'b1, 5'd5, 8'h3C, 1'b1);
    req(1'b0, 5'd5, 8'h00, 1'b0);

    req(1'b1, 5'd30, 8'h77, 1'b0);
    req(1'b0, 5'd30, 8'h00, 1'b0);
    req(1'b1, 5'd24, 8'h55, 1'b0);
    req(1'b0, 5'd23, 8'h00, 1'b0);

    repeat (6) @(posedge clk);
    #1;
    req(1'b0, 5'd20, 8'h00, 1'b0);
    req(1'b0, 5'd5, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_midflight",
        {28'd0, rsp_valid_a, rsp_valid_b,
         req_ready_a, req_ready_b}, 32'd0);
    qa.delete();
    qb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst2", {30'd0, req_ready_a, req_ready_b},
        32'd3);
    repeat (8) @(posedge clk);
    #1;

    for (int a = 0; a < 32; a++)
      req(1'b1, 5'(a), 8'hFF, 1'b1);
    req(1'b0, 5'd31, 8'h00, 1'b0, 1'b1);
    na = 0;
    nb = 0;
    viol = 0;
    repeat (24) @(negedge clk) begin
      if (clr_busy_a) na++;
      if (clr_busy_b) nb++;
      if (clr_busy_a && req_ready_a) viol++;
      if (clr_busy_b && req_ready_b) viol++;
    end
    chk("a_clr_cycles", 32'(na), 32'd16);
    chk("b_clr_cycles", 32'(nb), 32'd8);
    chk("ready_in_clear", 32'(viol), 32'd0);
    for (int a = IW; a < DA; a++) ma[a] = 8'h00;
    for (int a = IW; a < DB; a++) mb[a] = 8'h00;
    @(posedge clk);
    #1;
    for (int a = 0; a < 32; a++)
      req(1'b0, 5'(a), 8'h00, 1'b0);

    for (int a = IW; a < 32; a++)
      req(1'b1, 5'(a), 8'hFF, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("busy_after_rst", {30'd0, clr_busy_a, clr_busy_b},
        32'd0);
    for (int a = 16; a <= 20; a++) begin
      ma[a] = 8'h00;
      mb[a] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int a = IW; a < 32; a++)
      req(1'b0, 5'(a), 8'h00, 1'b0);

    repeat (8) @(posedge clk);
    #1;
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
